// File: rtl/program_loader.sv
// program_loader: turns a byte stream (count, lo/hi word pairs) into instruction-memory writes and holds the CPU until done.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module program_loader #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int          CW    = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, COUNT, LO, HI,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      count_q, count_n;
  logic [CW-1:0]      idx_q, idx_n;
  logic [7:0]         lo_q, lo_n;
  logic               ready_n, we_n, hold_n, done_n, err_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [INSTR_W-1:0] wdata_n;
  logic               xfer, hdr_ok, hi_ok, last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_n;
`endif

  always_comb begin
    state_n   = state;
    count_n   = count_q;
    idx_n     = idx_q;
    lo_n      = lo_q;
    we_n      = 1'b0;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    xfer      = in_valid && in_ready;
    hdr_ok    = (in_data != 8'd0) && (32'(in_data) <= DEPTH);
    // Only the low INSTR_W-8 bits of the high byte carry instruction bits.
    hi_ok     = (in_data >> (INSTR_W - 8)) == 8'd0;
    last_word = (idx_q == count_q - CW'(1));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_n    = csum_q;
    if (xfer) csum_n = csum_q ^ in_data;
`endif
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n = COUNT;
          idx_n   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_n  = '0;
`endif
        end
      end
      COUNT: begin
        if (xfer) begin
          if (hdr_ok) begin
            count_n = CW'(in_data);
            state_n = LO;
          end else begin
            state_n = ERR;
          end
        end
      end
      LO: begin
        if (xfer) begin
          lo_n    = in_data;
          state_n = HI;
        end
      end
      HI: begin
        if (xfer) begin
          if (hi_ok) begin
            we_n    = 1'b1;
            addr_n  = idx_q[ADDR_W-1:0];
            wdata_n = {in_data[INSTR_W-9:0], lo_q};
            idx_n   = idx_q + CW'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_n = last_word ? CHK : LO;
`else
            state_n = last_word ? DONE : LO;
`endif
          end else begin
            state_n = ERR;
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_n = (in_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_n = IDLE;
    endcase
    // Status outputs are registered from the next state so they track it exactly.
    ready_n = (state_n == COUNT) || (state_n == LO) || (state_n == HI)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              || (state_n == CHK)
`endif
              ;
    hold_n  = (state_n != DONE);
    done_n  = (state_n == DONE);
    err_n   = (state_n == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      lo_q      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state     <= state_n;
      count_q   <= count_n;
      idx_q     <= idx_n;
      lo_q      <= lo_n;
      in_ready  <= ready_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      cpu_hold  <= hold_n;
      done      <= done_n;
      error     <= err_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q    <= csum_n;
`endif
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (ADDR_W=4, INSTR_W=9).
// Checksum-specific steps are compiled when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       rst_n, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_we, cpu_hold, done, error;
  logic [3:0] mem_addr;
  logic [8:0] mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] wr_addr [0:63];
  logic [8:0] wr_data [0:63];
  int         wr_n = 0;

  program_loader #(.ADDR_W(4), .INSTR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Presents a byte; returns at the negedge before the edge that accepts it.
  task automatic send(input logic [7:0] b, input int unsigned gap);
    for (int unsigned g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && in_ready !== 1'b1; t++) @(negedge clk);
    if (in_ready !== 1'b1) check("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  int         base;
  logic [7:0] lo_b, hi_b, cs;
  logic [8:0] exp_d [0:15];

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_no_writes", wr_n, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // Two-word program with continuous in_valid.
    do_start();
    send(8'h02, 0); send(8'h43, 0); send(8'h01, 0); send(8'h15, 0); send(8'h00, 0);
    @(negedge clk);
    check("p2_last_we", mem_we, 1);
    check("p2_last_addr", mem_addr, 1);
    check("p2_last_data", mem_wdata, 9'h015);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("p2_chk_ready", in_ready, 1);
    check("p2_chk_not_done", done, 0);
    send(8'h55, 0);
    @(negedge clk);
`endif
    check("p2_done", done, 1);
    check("p2_cpu_hold", cpu_hold, 0);
    in_data = 8'h77;
    repeat (3) @(negedge clk);
    check("p2_extra_not_ready", in_ready, 0);
    check("p2_still_done", done, 1);
    in_valid = 1'b0;
    check("p2_write_count", wr_n, 2);
    check("p2_w0_addr", wr_addr[0], 0);
    check("p2_w0_data", wr_data[0], 9'h143);
    check("p2_w1_addr", wr_addr[1], 1);
    check("p2_w1_data", wr_data[1], 9'h015);

    // Bad headers, then recovery with a good stream.
    base = wr_n;
    do_start();
    check("restart_hold", cpu_hold, 1);
    check("restart_done_clr", done, 0);
    send(8'h00, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("hdr0_error", error, 1);
    check("hdr0_hold", cpu_hold, 1);
    check("hdr0_not_ready", in_ready, 0);
    do_start();
    check("restart_err_clr", error, 0);
    send(8'h11, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("hdr17_error", error, 1);
    check("hdr17_hold", cpu_hold, 1);
    check("hdr_no_writes", wr_n, base);
    do_start();
    send(8'h01, 0); send(8'h7F, 0); send(8'h01, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h7F, 0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("recover_done", done, 1);
    check("recover_error", error, 0);
    check("recover_writes", wr_n, base + 1);
    check("recover_data", wr_data[base], 9'h17F);

    // Illegal high byte on the second word.
    base = wr_n;
    do_start();
    send(8'h03, 0); send(8'h11, 0); send(8'h00, 0); send(8'h22, 0); send(8'h02, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("badhi_error", error, 1);
    check("badhi_no_we", mem_we, 0);
    check("badhi_hold", cpu_hold, 1);
    @(negedge clk);
    check("badhi_writes", wr_n, base + 1);
    check("badhi_w0_addr", wr_addr[base], 0);
    check("badhi_w0_data", wr_data[base], 9'h011);

    // Full 16-word program with random valid gaps.
    base = wr_n;
    do_start();
    cs = 8'h10;
    send(8'h10, $urandom_range(0, 1));
    for (int i = 0; i < 16; i++) begin
      lo_b = 8'(i * 37 + 5);
      hi_b = 8'(i & 1);
      exp_d[i] = {hi_b[0], lo_b};
      cs = cs ^ lo_b ^ hi_b;
      send(lo_b, $urandom_range(0, 1));
      send(hi_b, $urandom_range(0, 1));
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(cs, $urandom_range(0, 1));
`endif
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_done", done, 1);
    check("full_writes", wr_n, base + 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_addr%0d", i), wr_addr[base + i], i);
      check($sformatf("full_data%0d", i), wr_data[base + i], exp_d[i]);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    do_start();
    send(8'h01, 0); send(8'hAA, 0); send(8'h01, 0); send(8'hAA, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("csum_ok_done", done, 1);
    base = wr_n;
    do_start();
    send(8'h01, 0); send(8'hAA, 0); send(8'h01, 0); send(8'hAB, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("csum_bad_error", error, 1);
    check("csum_bad_done", done, 0);
    check("csum_bad_write", wr_data[base], 9'h1AA);
`endif

    // Asynchronous reset while in HI.
    do_start();
    send(8'h02, 0); send(8'h33, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_ready", in_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 0);
    check("arst_hold", cpu_hold, 1);
    check("arst_done", done, 0);
    check("arst_error", error, 0);
    check("arst_we", mem_we, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_data", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
